// File: rtl/axis_engine_pkg.sv
// Shared types and helpers for the AXI-Stream test engine: pattern modes, master FSM
// states and the byte-replicated word builder.
package axis_engine_pkg;

    localparam int unsigned MaxDataWidth = 128;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_REPL  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mst_state_e;

    // Callers truncate to their own data width.
    function automatic logic [MaxDataWidth-1:0] repl_word(input logic [7:0] lane);
        return {(MaxDataWidth / 8){lane}};
    endfunction

endpackage

// File: rtl/axis_capture_buffer.sv
// Slave-side capture: accepts one tlast-terminated packet into a strobe-masked buffer
// and exposes count/done/overflow status plus a registered read port.
module axis_capture_buffer
    import axis_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CAP_DEPTH  = 16,
    localparam int unsigned CNT_W     = $clog2(CAP_DEPTH + 1),
    localparam int unsigned IDX_W     = $clog2(CAP_DEPTH),
    localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] tdata_i,
    input  logic [STRB_W-1:0]     tstrb_i,
    input  logic                  tvalid_i,
    input  logic                  tlast_i,
    output logic                  tready_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  done_o,
    output logic                  overflow_o,
    input  logic [IDX_W-1:0]      rd_index_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [CAP_DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] wdata;
    logic [IDX_W-1:0]      waddr;
    logic                  hs, full, we;

    always_comb begin
        wdata = '0;
        for (int b = 0; b < STRB_W; b++) begin
            wdata[b*8 +: 8] = tstrb_i[b] ? tdata_i[b*8 +: 8] : 8'h00;
        end
    end

    // A beat coinciding with clear is discarded.
    assign hs    = tvalid_i && ready_q && !clear_i;
    assign full  = (count_q == CNT_W'(CAP_DEPTH));
    assign we    = hs && !full;
    assign waddr = count_q[IDX_W-1:0];

    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (hs) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            if (tlast_i) begin
                done_d = 1'b1;
            end
        end
        ready_d = !done_d;

        // Bypass so a read of the word being written returns the new data.
        rd_data_d = '0;
        if (CNT_W'(rd_index_i) < count_d) begin
            rd_data_d = (we && (rd_index_i == waddr)) ? wdata : mem_q[rd_index_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign tready_o   = ready_q;
    assign count_o    = count_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/axis_stream_engine.sv
// AXI-Stream test engine: programmable-pattern burst master plus an independent
// packet capture slave, both controlled from the AXI-Lite register file.
module axis_stream_engine
    import axis_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned CAP_DEPTH  = 16,
    localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1),
    localparam int unsigned CNT_W     = $clog2(CAP_DEPTH + 1),
    localparam int unsigned IDX_W     = $clog2(CAP_DEPTH),
    localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic                  cfg_clear,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_base,
    input  logic [DATA_WIDTH-1:0] cfg_step,
    input  logic [LEN_W-1:0]      cfg_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_W-1:0]     m_axis_tstrb,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [STRB_W-1:0]     s_axis_tstrb,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  mst_busy,
    output logic                  mst_done,
    output logic [CNT_W-1:0]      cap_count,
    output logic                  cap_done,
    output logic                  cap_overflow,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [DATA_WIDTH-1:0] rd_data
);

    mst_state_e            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [7:0]            lane_q, lane_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  last_beat;

    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    // data_q always holds the word on the bus; INCR accumulates into it directly.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        step_d  = step_q;
        lane_d  = lane_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (cfg_start && (cfg_len != '0)) begin
                    state_d = RUN;
                    mode_d  = cfg_mode;
                    step_d  = cfg_step;
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    lane_d  = cfg_base[7:0];
                    data_d  = (cfg_mode == MODE_REPL) ?
                              DATA_WIDTH'(repl_word(cfg_base[7:0])) : cfg_base;
                end
            end
            RUN: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        lane_d = lane_q + 8'd1;
                        case (mode_q)
                            MODE_FIXED: data_d = data_q;
                            MODE_REPL:  data_d = DATA_WIDTH'(repl_word(lane_q + 8'd1));
                            default:    data_d = data_q + step_q;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_clear) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            mode_q  <= '0;
            data_q  <= '0;
            step_q  <= '0;
            lane_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            step_q  <= step_d;
            lane_q  <= lane_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign m_axis_tvalid = (state_q == RUN);
    assign m_axis_tdata  = data_q;
    assign m_axis_tstrb  = {STRB_W{m_axis_tvalid}};
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign mst_busy      = m_axis_tvalid;
    assign mst_done      = done_q;

    axis_capture_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CAP_DEPTH  (CAP_DEPTH)
    ) u_capture (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .clear_i    (cfg_clear),
        .tdata_i    (s_axis_tdata),
        .tstrb_i    (s_axis_tstrb),
        .tvalid_i   (s_axis_tvalid),
        .tlast_i    (s_axis_tlast),
        .tready_o   (s_axis_tready),
        .count_o    (cap_count),
        .done_o     (cap_done),
        .overflow_o (cap_overflow),
        .rd_index_i (rd_index),
        .rd_data_o  (rd_data)
    );

endmodule

// File: doc/axis_stream_engine.md
Name: axis_stream_engine

Overview:
- Parametrised successor of the fixed 8-beat stream master/slave pair behind our AXI-Lite test IP.
- Master side emits a configurable-length burst using one of three programmable data patterns.
- Slave side captures a tlast-terminated packet into an indexed buffer with count, done and overflow status.
- Sits between the AXI-Lite register file (which drives the cfg_*/rd_* ports) and the m00_axis/s00_axis ports of the block design.

Parameters:
- DATA_WIDTH, 32: stream data width; multiple of 8, 8..128.
- MAX_BURST, 256: maximum master burst length in beats.
- CAP_DEPTH, 16: capture buffer depth in words; power of two.
- LEN_W (localparam), $clog2(MAX_BURST+1): width of cfg_len.
- CNT_W (localparam), $clog2(CAP_DEPTH+1): width of cap_count.
- IDX_W (localparam), $clog2(CAP_DEPTH): width of rd_index.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse: start a master burst.
- cfg_clear  in  1  one-cycle pulse: clear master done flag and capture state.
- cfg_mode  in  2  pattern: 0 INCR, 1 FIXED, 2 REPL; 3 behaves as INCR.
- cfg_base  in  DATA_WIDTH  first data word.
- cfg_step  in  DATA_WIDTH  INCR increment.
- cfg_len  in  LEN_W  burst length in beats.
- m_axis_tdata  out  DATA_WIDTH  master stream data.
- m_axis_tstrb  out  DATA_WIDTH/8  master stream byte strobes.
- m_axis_tvalid  out  1  master stream valid.
- m_axis_tlast  out  1  master stream last beat.
- m_axis_tready  in  1  master stream ready.
- s_axis_tdata  in  DATA_WIDTH  slave stream data.
- s_axis_tstrb  in  DATA_WIDTH/8  slave stream byte strobes.
- s_axis_tvalid  in  1  slave stream valid.
- s_axis_tlast  in  1  slave stream last beat.
- s_axis_tready  out  1  slave stream ready.
- mst_busy  out  1  master burst in progress.
- mst_done  out  1  sticky: burst complete.
- cap_count  out  CNT_W  number of words stored.
- cap_done  out  1  sticky: tlast received.
- cap_overflow  out  1  sticky: beat dropped because buffer was full.
- rd_index  in  IDX_W  capture buffer read address.
- rd_data  out  DATA_WIDTH  capture buffer read data.

Behaviour:
- Reset (ARESET=1 at a clock edge): every output is 0, including s_axis_tready; s_axis_tready rises on the first edge after reset deasserts. Buffer RAM is not reset.
- Master FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN: cfg_start=1 and cfg_len!=0. Mode, base, step and len are latched; beat counter=0; mst_done=0.
  - cfg_start with cfg_len=0: ignored.
  - cfg_start while in RUN: ignored.
  - RUN: m_axis_tvalid=1 and mst_busy=1. First beat is valid on the cycle after the start edge.
  - tdata/tlast are held stable while tvalid=1 and tready=0.
  - Handshake: beat counter +1, next word registered, so back-to-back beats run at 1 beat/cycle.
  - Handshake on beat len-1 (tlast=1): go to DONE, tvalid=0, mst_done=1 on the next cycle.
- Data pattern for beat i:
  - INCR: base + i*step, using a running accumulator, modulo 2^DATA_WIDTH.
  - FIXED: base.
  - REPL: every byte lane = base[7:0]+i, modulo 256.
- m_axis_tstrb: all ones whenever tvalid=1, otherwise 0.
- cfg_clear: master goes to IDLE from any state, including mid-burst, and deasserts tvalid the next cycle; mst_done=0. cfg_clear wins over a simultaneous cfg_start.
- Capture side:
  - s_axis_tready = !cap_done (and low in reset).
  - On a handshake with cap_count<CAP_DEPTH: store the word at address cap_count, with bytes whose tstrb bit is 0 stored as 0x00; cap_count +1.
  - On a handshake with cap_count==CAP_DEPTH: word is dropped, cap_overflow=1, and the beat is still accepted (no stall).
  - Handshake with tlast=1: word stored (if room), cap_done=1, tready=0 from the next cycle.
  - cfg_clear: cap_count, cap_done and cap_overflow = 0; tready=1 next cycle. A beat in the same cycle as cfg_clear is discarded.
- Read port: rd_data is registered with 1-cycle latency. Returns mem[rd_index] if rd_index<cap_count, else 0. A read of a word written in the same cycle returns the new word.
- Master and capture sides are fully independent and may run concurrently.

Decomposition:
- axis_engine_pkg:
  - mode enum: MODE_INCR, MODE_FIXED, MODE_REPL.
  - master state enum: IDLE, RUN, DONE.
  - function for the REPL word.
- One sub-module, axis_capture_buffer: slave handshake, strobe masking, count/done/overflow logic, RAM and registered read port.
- Master FSM and pattern generator live in the top module.

Test Plan:
- Defaults, INCR, base=0xFF00, step=1, len=8, tready tied 1 -> 8 consecutive beats 0xFF00..0xFF07, tlast only on the 8th, mst_done=1 one cycle after.
- REPL, base=0xA0, len=4, tready toggling 1/0 each cycle -> beats 0xA0A0A0A0..0xA3A3A3A3; tdata stable during every stall cycle.
- Slave: drive 8 beats, word i = {4{8'(i)}}, tlast on beat 7; then rd_index 0..7 -> rd_data = 0x00000000..0x07070707; cap_count=8; cap_done=1; tready=0; rd_index=8 -> rd_data=0.
- Slave: 20 beats, tlast on the 20th, CAP_DEPTH=16 -> cap_count=16, cap_overflow=1, words 16..19 absent; cfg_clear -> count, done and overflow all 0, tready=1.
- Slave: beat 2 with tstrb=4'b0101 and tdata=0xDEADBEEF -> rd_data=0x00AD00EF.
- Master: cfg_clear at beat 3 of a 256-beat burst -> tvalid=0 next cycle, state IDLE; a new start with cfg_len=0 is ignored; ARESET mid-burst -> all outputs 0.
